// File: rtl/cbuf_pkg.sv
// Shared definitions for the conditional-buffer split sink: sizes,
// pointer width, input FSM states and the stored FIFO entry layout.
package cbuf_pkg;

    localparam int WIDTH = 11;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    // One stored word: the control token on top, the data token below it.
    typedef struct packed {
        logic             ctl;
        logic [WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a four-phase request arriving from the
// asynchronous upstream buffer. Clears to 0 on asynchronous reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw request through two flops to settle metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cbuf_split_sink.sv
// Joins the R (data) and C (control) four-phase channels into one word,
// queues it in a small FIFO and steers the head word to port 0 (C=0) or
// port 1 (C=1).
//
// Output handshake: a word leaves on the edge where the selected port has
// valid and ready both high. Valid never drops without a pop, o_data holds
// the head word while either valid is high, and only one valid is high at
// a time. The head word blocks everything behind it.
module cbuf_split_sink #(
    parameter int WIDTH = cbuf_pkg::WIDTH,
    parameter int DEPTH = cbuf_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r_req,
    input  logic [WIDTH-1:0] r_data,
    output logic             r_ack,
    input  logic             c_req,
    input  logic             c_data,
    output logic             c_ack,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             full,
    output logic             fsm_state
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    import cbuf_pkg::*;

    logic             rs;
    logic             cs;
    state_t           state;
    state_t           state_next;
    logic             wr_en;
    logic             pop;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             full_next;
    logic             valid_next;
    entry_t           head_next;

    sync2 u_r_sync (.clk(clk), .reset(reset), .d(r_req), .q(rs));
    sync2 u_c_sync (.clk(clk), .reset(reset), .d(c_req), .q(cs));

    // Input state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Join both requests before capturing; hold acks until both requests drop.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (rs && cs && !full) begin
                    wr_en      = 1'b1;
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (!rs && !cs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Acks come straight from the state so reset drops them at once.
    assign r_ack     = (state == ACKED);
    assign c_ack     = (state == ACKED);
    assign fsm_state = (state == ACKED);

    assign pop = (o0_valid && o0_ready) || (o1_valid && o1_ready);

    // Next pointers, registered full flag and the word that becomes the head.
    // Validity is judged against the pre-write wr_ptr, so a word written into
    // an empty FIFO shows up on the following edge.
    always_comb begin
        wr_ptr_next = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_next = pop   ? (rd_ptr + PTR_ONE) : rd_ptr;
        full_next   = (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]) &&
                      (wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]);
        valid_next  = (rd_ptr_next != wr_ptr);
        head_next   = mem[rd_ptr_next[IDX_W-1:0]];
    end

    // FIFO storage, pointers and full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[IDX_W-1:0]] <= '{ctl: c_data, data: r_data};
            end
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= full_next;
        end
    end

    // Registered output steering of the head word by its control bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o0_valid <= 1'b0;
            o1_valid <= 1'b0;
            o_data   <= '0;
        end else begin
            o0_valid <= valid_next && !head_next.ctl;
            o1_valid <= valid_next &&  head_next.ctl;
            o_data   <= head_next.data;
        end
    end

endmodule

// File: tb/tb_cbuf_split_sink.sv
// Directed bench for cbuf_split_sink: a queue model of the stored words,
// one per-cycle compare process, and literal checks for each scenario.
module tb_cbuf_split_sink;

    localparam int W     = 11;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         r_req;
    logic [W-1:0] r_data;
    logic         r_ack;
    logic         c_req;
    logic         c_data;
    logic         c_ack;
    logic         o0_valid;
    logic         o0_ready;
    logic         o1_valid;
    logic         o1_ready;
    logic [W-1:0] o_data;
    logic         full;
    logic         fsm_state;

    int           checks;
    int           errors;
    bit           check_en;
    bit           wrap_done;
    logic [W:0]   exp_q[$];
    logic [W-1:0] pop_log[$];
    logic [W:0]   head;

    cbuf_split_sink dut (
        .clk(clk), .reset(reset),
        .r_req(r_req), .r_data(r_data), .r_ack(r_ack),
        .c_req(c_req), .c_data(c_data), .c_ack(c_ack),
        .o0_valid(o0_valid), .o0_ready(o0_ready),
        .o1_valid(o1_valid), .o1_ready(o1_ready),
        .o_data(o_data), .full(full), .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the queue model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (check_en) begin
                check("full_flag", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
                check("one_hot_valid", {31'd0, o0_valid && o1_valid}, 32'd0);
                if (o0_valid || o1_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", {31'd0, o0_valid || o1_valid}, 32'd0);
                    end else begin
                        head = exp_q[0];
                        check("head_word", {20'd0, o1_valid, o_data}, {20'd0, head});
                        if ((o0_valid && o0_ready) || (o1_valid && o1_ready)) begin
                            void'(exp_q.pop_front());
                            pop_log.push_back(o_data);
                        end
                    end
                end
            end
        end
    end

    task automatic raise(input logic ctl, input logic [W-1:0] d, input logic rq, input logic cq);
        r_data = d;
        c_data = ctl;
        r_req  = rq;
        c_req  = cq;
    endtask

    // Complete a four-phase exchange on both channels and log the word.
    task automatic finish_token(input logic ctl, input logic [W-1:0] d, input int max_edges);
        int edges;
        int rel;
        r_data = d;
        c_data = ctl;
        r_req  = 1'b1;
        c_req  = 1'b1;
        edges  = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (r_ack && c_ack) begin
                edges = i;
                break;
            end
        end
        check("ack_seen", {31'd0, edges != 0}, 32'd1);
        if (edges != 0) begin
            exp_q.push_back({ctl, d});
            check("req_to_ack", {31'd0, edges <= max_edges}, 32'd1);
        end
        r_req = 1'b0;
        c_req = 1'b0;
        rel   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!r_ack && !c_ack) begin
                rel = i;
                break;
            end
        end
        check("ack_release_edges", rel, 32'd3);
    endtask

    task automatic send(input logic ctl, input logic [W-1:0] d, input int max_edges);
        raise(ctl, d, 1'b1, 1'b1);
        finish_token(ctl, d, max_edges);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !o0_valid && !o1_valid) break;
            @(negedge clk);
        end
        check("drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        check_en  = 1'b0;
        wrap_done = 1'b0;
        reset     = 1'b0;
        r_req     = 1'b0;
        c_req     = 1'b0;
        r_data    = '0;
        c_data    = 1'b0;
        o0_ready  = 1'b0;
        o1_ready  = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_acks", {30'd0, r_ack, c_ack}, 32'd0);
        check("rst_valids", {30'd0, o0_valid, o1_valid}, 32'd0);
        check("rst_data", {21'd0, o_data}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_fsm", {31'd0, fsm_state}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        // Single token to port 1.
        send(1'b1, 11'h5A3, 3);
        check("single_o1_valid", {31'd0, o1_valid}, 32'd1);
        check("single_o0_valid", {31'd0, o0_valid}, 32'd0);
        check("single_data", {21'd0, o_data}, 32'h5A3);
        o1_ready = 1'b1;
        @(negedge clk);
        o1_ready = 1'b0;
        @(negedge clk);
        check("single_popped", {30'd0, o0_valid, o1_valid}, 32'd0);

        // Join: R alone must not be acknowledged.
        o0_ready = 1'b1;
        raise(1'b0, 11'h155, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("join_no_ack", {30'd0, r_ack, c_ack}, 32'd0);
        finish_token(1'b0, 11'h155, 3);
        wait_empty();

        // Fill to DEPTH, then a blocked fifth token.
        o0_ready = 1'b0;
        pop_log.delete();
        for (int i = 1; i <= 4; i++) send(1'b0, W'(i), 3);
        check("fill_full", {31'd0, full}, 32'd1);
        raise(1'b0, 11'd5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("fifth_no_ack", {30'd0, r_ack, c_ack}, 32'd0);
        o0_ready = 1'b1;
        finish_token(1'b0, 11'd5, 300);
        wait_empty();
        check("fill_pop_count", pop_log.size(), 32'd5);
        if (pop_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("fill_order", {21'd0, pop_log[i]}, i + 1);
        end

        // Head-of-line blocking.
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        send(1'b1, 11'h111, 3);
        send(1'b0, 11'h222, 3);
        o0_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hol_o0_blocked", {30'd0, o0_valid, o1_valid}, 32'd1);
        end
        o1_ready = 1'b1;
        @(negedge clk);
        o1_ready = 1'b0;
        check("hol_o0_after", {30'd0, o0_valid, o1_valid}, 32'd2);
        check("hol_data_after", {21'd0, o_data}, 32'h222);
        wait_empty();

        // Pointer wrap with random readiness.
        pop_log.delete();
        fork
            begin
                for (int i = 0; i < 20; i++) send(1'(i % 2), W'($urandom_range(0, 2047)), 300);
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    @(negedge clk);
                    o0_ready = 1'($urandom_range(0, 1));
                    o1_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        o0_ready = 1'b1;
        o1_ready = 1'b1;
        wait_empty();
        check("wrap_pop_count", pop_log.size(), 32'd20);

        // Reset while ACKED with a word already stored.
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        send(1'b0, 11'h0AB, 3);
        raise(1'b1, 11'h3CD, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r_ack) break;
        end
        check("pre_reset_acked", {31'd0, fsm_state}, 32'd1);
        check_en = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_acks", {30'd0, r_ack, c_ack}, 32'd0);
        check("mid_rst_valids", {30'd0, o0_valid, o1_valid}, 32'd0);
        check("mid_rst_data", {21'd0, o_data}, 32'd0);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        r_req = 1'b0;
        c_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check_en = 1'b1;
        check("post_rst_empty", {30'd0, o0_valid, o1_valid}, 32'd0);
        pop_log.delete();
        send(1'b0, 11'h7FF, 3);
        o0_ready = 1'b1;
        wait_empty();
        check("post_rst_word", pop_log.size(), 32'd1);
        if (pop_log.size() == 1) check("post_rst_data", {21'd0, pop_log[0]}, 32'h7FF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
